// File: rtl/mem_stage.sv
// mem_stage: memory pipeline stage between execute and writeback.
// Registers the execute payload, aligns and extends SRAM load data and
// drives the writeback bus. SRAM read data is parked in a private buffer
// while writeback stalls, because the SRAM presents it for one cycle only.
// Ports:
//   clk, reset        clock and synchronous active-low reset
//   EXreg_valid/bus   instruction offered by the execute stage
//   MEM_allow_in      this stage accepts EXreg_bus this cycle
//   WB_allow_in       writeback accepts MEMreg_bus this cycle
//   data_sram_rdata   SRAM read data, one cycle after the request
//   MEMreg_valid/bus  instruction presented to writeback
//   MEM_fwd_*         destination info of the held instruction for ID bypass
module mem_stage #(
   parameter int EX_BUS_W  = 78,
   parameter int MEM_BUS_W = 70
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 EXreg_valid,
   input  logic [EX_BUS_W-1:0]  EXreg_bus,
   output logic                 MEM_allow_in,
   input  logic                 WB_allow_in,
   input  logic [31:0]          data_sram_rdata,
   output logic                 MEMreg_valid,
   output logic [MEM_BUS_W-1:0] MEMreg_bus,
   output logic                 MEM_fwd_we,
   output logic [4:0]           MEM_fwd_waddr,
   output logic [31:0]          MEM_fwd_wdata
);
   logic        mem_valid, first_cycle, buf_valid;
   logic [31:0] buf_data;
   logic [2:0]  ld_op;
   logic [31:0] alu_result, pc;
   logic        rf_we, res_from_mem;
   logic [4:0]  rf_waddr;
   logic        accept, capture;
   logic [31:0] raw, load_result, rf_wdata;
   logic [7:0]  byte_val;
   logic [15:0] half_val;
   logic        unused_mem_we;

   // This stage never stalls on its own, so ready_go is constant 1.
   assign MEM_allow_in  = !mem_valid | WB_allow_in;
   assign accept        = EXreg_valid & MEM_allow_in;
   // Only the first cycle carries live SRAM data; park it if writeback stalls.
   assign capture       = mem_valid & first_cycle & res_from_mem & !WB_allow_in;
   // Store byte enables are consumed by the SRAM port upstream, not here.
   assign unused_mem_we = ^EXreg_bus[42:39];

   always_ff @(posedge clk) begin
      if (!reset) begin
         mem_valid    <= 1'b0;
         first_cycle  <= 1'b0;
         buf_valid    <= 1'b0;
         buf_data     <= '0;
         ld_op        <= '0;
         alu_result   <= '0;
         rf_we        <= 1'b0;
         res_from_mem <= 1'b0;
         rf_waddr     <= '0;
         pc           <= '0;
      end else begin
         if (MEM_allow_in) mem_valid <= EXreg_valid;
         first_cycle <= accept;
         if (accept) {ld_op, alu_result, rf_we, res_from_mem, rf_waddr, pc} <= {EXreg_bus[77:43], EXreg_bus[38:0]};
         if (MEM_allow_in) buf_valid <= 1'b0;
         else if (capture) buf_valid <= 1'b1;
         if (capture) buf_data <= data_sram_rdata;
      end
   end

   always_comb begin
      raw         = buf_valid ? buf_data : data_sram_rdata;
      byte_val    = raw[{alu_result[1:0], 3'b000} +: 8];
      half_val    = alu_result[1] ? raw[31:16] : raw[15:0];
      load_result = ld_op == 3'b001 ? {{24{byte_val[7]}}, byte_val} :
                    ld_op == 3'b101 ? {24'd0, byte_val} :
                    ld_op == 3'b010 ? {{16{half_val[15]}}, half_val} :
                    ld_op == 3'b110 ? {16'd0, half_val} : raw;
      rf_wdata    = res_from_mem ? load_result : alu_result;
   end

   assign MEMreg_valid  = mem_valid;
   assign MEMreg_bus    = {rf_we, rf_waddr, rf_wdata, pc};
   assign MEM_fwd_we    = mem_valid & rf_we;
   assign MEM_fwd_waddr = rf_waddr;
   assign MEM_fwd_wdata = rf_wdata;
endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: self-checking bench for mem_stage with directed and random stimulus.
module tb_mem_stage;
   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        EXreg_valid = 1'b0;
   logic [77:0] EXreg_bus = '0;
   logic        MEM_allow_in;
   logic        WB_allow_in = 1'b1;
   logic [31:0] data_sram_rdata = '0;
   logic        MEMreg_valid;
   logic [69:0] MEMreg_bus;
   logic        MEM_fwd_we;
   logic [4:0]  MEM_fwd_waddr;
   logic [31:0] MEM_fwd_wdata;
   int checks = 0;
   int failures = 0;

   mem_stage dut (
      .clk(clk), .reset(reset), .EXreg_valid(EXreg_valid), .EXreg_bus(EXreg_bus),
      .MEM_allow_in(MEM_allow_in), .WB_allow_in(WB_allow_in), .data_sram_rdata(data_sram_rdata),
      .MEMreg_valid(MEMreg_valid), .MEMreg_bus(MEMreg_bus), .MEM_fwd_we(MEM_fwd_we),
      .MEM_fwd_waddr(MEM_fwd_waddr), .MEM_fwd_wdata(MEM_fwd_wdata)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [77:0] mk(input logic [2:0] op, input logic [31:0] alu, input logic [3:0] mwe,
                                      input logic we, input logic rfm, input logic [4:0] wa, input logic [31:0] p);
      return {op, alu, mwe, we, rfm, wa, p};
   endfunction

   // Load result from the architectural rules, using plain integer arithmetic.
   function automatic logic [31:0] exp_load(input logic [2:0] op, input logic [1:0] a, input logic [31:0] w);
      longint unsigned v = w;
      longint unsigned ai = a;
      longint unsigned b = (v / (256 ** ai)) % 256;
      longint unsigned h = (v / (65536 ** (ai / 2))) % 65536;
      logic [31:0] r;
      case (op)
         3'b001: begin r = 32'(b); if (b >= 128) r = r - 32'd256; end
         3'b101: r = 32'(b);
         3'b010: begin r = 32'(h); if (h >= 32768) r = r - 32'd65536; end
         3'b110: r = 32'(h);
         default: r = w;
      endcase
      return r;
   endfunction

   task automatic test_reset();
      reset = 1'b0;
      EXreg_valid = 1'b1;
      EXreg_bus = mk(3'b000, 32'h0000_0042, 4'h0, 1'b1, 1'b0, 5'd9, 32'h1C00_0100);
      for (int i = 0; i < 2; i++) begin
         tick();
         checks++; if (MEMreg_valid !== 1'b0) begin failures++; $display("FAIL reset_valid: got %b expected 0", MEMreg_valid); end
         checks++; if (MEM_fwd_we !== 1'b0) begin failures++; $display("FAIL reset_fwd_we: got %b expected 0", MEM_fwd_we); end
         checks++; if (MEM_allow_in !== 1'b1) begin failures++; $display("FAIL reset_allow_in: got %b expected 1", MEM_allow_in); end
      end
      reset = 1'b1;
      tick();
      EXreg_valid = 1'b0;
      #1;
      checks++; if (MEMreg_valid !== 1'b1) begin failures++; $display("FAIL reset_release_valid: got %b expected 1", MEMreg_valid); end
      checks++; if (MEMreg_bus !== {1'b1, 5'd9, 32'h0000_0042, 32'h1C00_0100}) begin failures++; $display("FAIL reset_release_bus: got %h expected %h", MEMreg_bus, {1'b1, 5'd9, 32'h0000_0042, 32'h1C00_0100}); end
      tick();
      checks++; if (MEMreg_valid !== 1'b0) begin failures++; $display("FAIL reset_release_retire: got %b expected 0", MEMreg_valid); end
   endtask

   task automatic test_alu();
      WB_allow_in = 1'b1;
      EXreg_valid = 1'b1;
      EXreg_bus = mk(3'b000, 32'h1234_5678, 4'h0, 1'b1, 1'b0, 5'd5, 32'h1C00_0000);
      tick();
      EXreg_valid = 1'b0;
      data_sram_rdata = 32'hAAAA_5555;
      #1;
      checks++; if (MEMreg_valid !== 1'b1) begin failures++; $display("FAIL alu_valid: got %b expected 1", MEMreg_valid); end
      checks++; if (MEMreg_bus !== {1'b1, 5'd5, 32'h1234_5678, 32'h1C00_0000}) begin failures++; $display("FAIL alu_bus: got %h expected %h", MEMreg_bus, {1'b1, 5'd5, 32'h1234_5678, 32'h1C00_0000}); end
      checks++; if ({MEM_fwd_we, MEM_fwd_waddr, MEM_fwd_wdata} !== {1'b1, 5'd5, 32'h1234_5678}) begin failures++; $display("FAIL alu_fwd: got %b %h %h expected 1 05 12345678", MEM_fwd_we, MEM_fwd_waddr, MEM_fwd_wdata); end
      tick();
      checks++; if (MEMreg_valid !== 1'b0) begin failures++; $display("FAIL alu_retire: got %b expected 0", MEMreg_valid); end
   endtask

   task automatic test_loads();
      logic [2:0]  ops [5] = '{3'b001, 3'b101, 3'b010, 3'b110, 3'b000};
      logic [1:0]  offs[5] = '{2'd3, 2'd3, 2'd2, 2'd0, 2'd2};
      logic [31:0] exps[5] = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_80FF, 32'h0000_7F01, 32'h80FF_7F01};
      WB_allow_in = 1'b1;
      for (int i = 0; i < 5; i++) begin
         EXreg_valid = 1'b1;
         EXreg_bus = mk(ops[i], {30'h0400_0000, offs[i]}, 4'h0, 1'b1, 1'b1, 5'(i + 1), 32'h1C00_0200 + 32'(4 * i));
         tick();
         EXreg_valid = 1'b0;
         data_sram_rdata = 32'h80FF_7F01;
         #1;
         checks++; if (MEMreg_bus[63:32] !== exps[i]) begin failures++; $display("FAIL load_%0d op=%b a=%0d: got %h expected %h", i, ops[i], offs[i], MEMreg_bus[63:32], exps[i]); end
         tick();
      end
   endtask

   task automatic test_stall();
      WB_allow_in = 1'b0;
      EXreg_valid = 1'b1;
      EXreg_bus = mk(3'b000, 32'h0000_1000, 4'h0, 1'b1, 1'b1, 5'd12, 32'h1C00_0300);
      tick();
      EXreg_bus = mk(3'b000, 32'h0BAD_F00D, 4'h0, 1'b1, 1'b0, 5'd13, 32'h1C00_0304);
      for (int i = 0; i < 3; i++) begin
         data_sram_rdata = (i == 0) ? 32'hDEAD_BEEF : 32'h0;
         #1;
         checks++; if (MEMreg_bus[63:32] !== 32'hDEAD_BEEF) begin failures++; $display("FAIL stall_wdata_%0d: got %h expected deadbeef", i, MEMreg_bus[63:32]); end
         checks++; if (MEM_allow_in !== 1'b0) begin failures++; $display("FAIL stall_allow_in_%0d: got %b expected 0", i, MEM_allow_in); end
         checks++; if (MEMreg_valid !== 1'b1) begin failures++; $display("FAIL stall_valid_%0d: got %b expected 1", i, MEMreg_valid); end
         if (i < 2) tick();
      end
      WB_allow_in = 1'b1;
      #1;
      checks++; if (MEM_allow_in !== 1'b1) begin failures++; $display("FAIL stall_release_allow_in: got %b expected 1", MEM_allow_in); end
      tick();
      EXreg_valid = 1'b0;
      #1;
      checks++; if (MEMreg_bus !== {1'b1, 5'd13, 32'h0BAD_F00D, 32'h1C00_0304}) begin failures++; $display("FAIL stall_next_bus: got %h expected %h", MEMreg_bus, {1'b1, 5'd13, 32'h0BAD_F00D, 32'h1C00_0304}); end
      tick();
      checks++; if (MEMreg_valid !== 1'b0) begin failures++; $display("FAIL stall_drain: got %b expected 0", MEMreg_valid); end
   endtask

   task automatic test_back_to_back();
      logic [77:0] ins[4];
      logic [31:0] words[4] = '{32'h1111_2222, 32'h9876_F543, 32'hC3A5_0F0F, 32'h7777_8888};
      logic [31:0] exp;
      ins[0] = mk(3'b000, 32'h0000_00A0, 4'h0, 1'b1, 1'b0, 5'd1, 32'h1C00_0400);
      ins[1] = mk(3'b001, 32'h0000_0101, 4'h0, 1'b1, 1'b1, 5'd2, 32'h1C00_0404);
      ins[2] = mk(3'b110, 32'h0000_0202, 4'h0, 1'b1, 1'b1, 5'd3, 32'h1C00_0408);
      ins[3] = mk(3'b000, 32'h0000_0300, 4'hF, 1'b0, 1'b0, 5'd4, 32'h1C00_040C);
      WB_allow_in = 1'b1;
      for (int i = 0; i < 5; i++) begin
         EXreg_valid = (i < 4);
         if (i < 4) EXreg_bus = ins[i];
         if (i > 0) begin
            data_sram_rdata = words[i - 1];
            #1;
            exp = ins[i - 1][37] ? exp_load(ins[i - 1][77:75], ins[i - 1][44:43], words[i - 1]) : ins[i - 1][74:43];
            checks++; if (MEMreg_bus !== {ins[i - 1][38], ins[i - 1][36:32], exp, ins[i - 1][31:0]}) begin failures++; $display("FAIL b2b_bus_%0d: got %h expected %h", i - 1, MEMreg_bus, {ins[i - 1][38], ins[i - 1][36:32], exp, ins[i - 1][31:0]}); end
            checks++; if (MEM_allow_in !== 1'b1) begin failures++; $display("FAIL b2b_allow_in_%0d: got %b expected 1", i - 1, MEM_allow_in); end
         end
         tick();
      end
      checks++; if (MEMreg_valid !== 1'b0) begin failures++; $display("FAIL b2b_drain: got %b expected 0", MEMreg_valid); end
   endtask

   task automatic test_reset_mid_stall();
      WB_allow_in = 1'b0;
      EXreg_valid = 1'b1;
      EXreg_bus = mk(3'b000, 32'h0000_2000, 4'h0, 1'b1, 1'b1, 5'd20, 32'h1C00_0500);
      tick();
      EXreg_valid = 1'b0;
      data_sram_rdata = 32'hCAFE_F00D;
      tick();
      data_sram_rdata = 32'h0;
      #1;
      checks++; if (MEMreg_bus[63:32] !== 32'hCAFE_F00D) begin failures++; $display("FAIL rms_buffered: got %h expected cafef00d", MEMreg_bus[63:32]); end
      reset = 1'b0;
      tick();
      reset = 1'b1;
      checks++; if (MEMreg_valid !== 1'b0) begin failures++; $display("FAIL rms_valid: got %b expected 0", MEMreg_valid); end
      checks++; if (MEM_allow_in !== 1'b1) begin failures++; $display("FAIL rms_allow_in: got %b expected 1", MEM_allow_in); end
      WB_allow_in = 1'b1;
      EXreg_valid = 1'b1;
      EXreg_bus = mk(3'b000, 32'h0000_3000, 4'h0, 1'b1, 1'b1, 5'd21, 32'h1C00_0504);
      tick();
      EXreg_valid = 1'b0;
      data_sram_rdata = 32'h1357_9BDF;
      #1;
      checks++; if (MEMreg_bus[63:32] !== 32'h1357_9BDF) begin failures++; $display("FAIL rms_live_data: got %h expected 13579bdf", MEMreg_bus[63:32]); end
      tick();
   endtask

   task automatic test_random();
      logic        m_valid = 1'b0, m_first = 1'b0;
      logic [77:0] m_ins = '0, nxt;
      logic [31:0] m_word = '0, exp;
      logic        ev, wb, allow;
      EXreg_valid = 1'b0;
      WB_allow_in = 1'b1;
      tick();
      for (int c = 0; c < 400; c++) begin
         ev = $urandom_range(0, 3) != 0;
         wb = $urandom_range(0, 2) != 0;
         nxt = mk(3'($urandom), $urandom, 4'($urandom), 1'($urandom), 1'($urandom), 5'($urandom), $urandom);
         EXreg_valid = ev;
         EXreg_bus = nxt;
         WB_allow_in = wb;
         data_sram_rdata = (m_valid && m_first) ? m_word : $urandom;
         #1;
         allow = !m_valid || wb;
         checks++; if (MEM_allow_in !== allow) begin failures++; $display("FAIL rnd_allow_in c=%0d: got %b expected %b", c, MEM_allow_in, allow); end
         checks++; if (MEMreg_valid !== m_valid || MEM_fwd_we !== (m_valid & m_ins[38])) begin failures++; $display("FAIL rnd_valid c=%0d: got %b/%b expected %b/%b", c, MEMreg_valid, MEM_fwd_we, m_valid, m_valid & m_ins[38]); end
         if (m_valid) begin
            exp = m_ins[37] ? exp_load(m_ins[77:75], m_ins[44:43], m_word) : m_ins[74:43];
            checks++; if (MEMreg_bus !== {m_ins[38], m_ins[36:32], exp, m_ins[31:0]} || MEM_fwd_wdata !== exp || MEM_fwd_waddr !== m_ins[36:32]) begin failures++; $display("FAIL rnd_bus c=%0d: got %h expected %h", c, MEMreg_bus, {m_ins[38], m_ins[36:32], exp, m_ins[31:0]}); end
         end
         if (allow) begin
            m_valid = ev;
            m_first = ev;
            if (ev) begin m_ins = nxt; m_word = $urandom; end
         end else m_first = 1'b0;
         tick();
      end
      EXreg_valid = 1'b0;
      WB_allow_in = 1'b1;
      tick();
   endtask

   initial begin
      test_reset();
      test_alu();
      test_loads();
      test_stall();
      test_back_to_back();
      test_reset_mid_stall();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
